// File: rtl/m2_processing_unit.sv
// Single-bus datapath: register file, ALU with Y operand, MAR/MDR, PC/IR and an instruction-fetch FSM.
// Define M2_PU_EXT_FLAGS_EN to add registered carry/negative/overflow flags (c_flag, n_flag, v_flag).
module m2_processing_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter int                   NUM_REGS  = 8,
    parameter logic [WORD_SIZE-1:0] PC_RESET  = '0,
    localparam int                  RSEL_W    = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_wr_en,
    input  logic [RSEL_W-1:0]    reg_wr_sel,
    input  logic [RSEL_W-1:0]    reg_rd_sel,
    input  logic [1:0]           bus_src,
    input  logic [2:0]           alu_op,
    input  logic                 load_alu_y,
    input  logic                 load_flags,
    input  logic                 load_mar,
    input  logic                 load_mdr,
    input  logic                 load_pc,
    input  logic                 inc_pc,
    input  logic                 fetch_req,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic                 mem_rd,
    output logic                 fetch_busy,
    output logic [WORD_SIZE-1:0] instruction,
    output logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] mdr,
    output logic                 z_flag,
    output logic [1:0]           fetch_state,
`ifdef M2_PU_EXT_FLAGS_EN
    output logic                 c_flag,
    output logic                 n_flag,
    output logic                 v_flag,
`endif
    output logic [WORD_SIZE-1:0] bus_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } fetch_state_e;

    fetch_state_e         state_q, state_d;
    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] alu_y_q, mar_q, mdr_q, ir_q, pc_q, pc_d;
    logic                 z_q;
    logic [WORD_SIZE-1:0] rf_rdata, alu_a, alu_res, bus;
    logic                 in_req, fetch_done;

    assign rf_rdata = regs_q[reg_rd_sel];

    // ALU operand A is the bus with the ALU's own source replaced by the register
    // file read; this breaks the bus->ALU->bus loop and makes bus_src=01 compute
    // R[reg_rd_sel] op Y.
    always_comb begin
        case (bus_src)
            2'b10:   alu_a = mdr_q;
            2'b11:   alu_a = pc_q;
            default: alu_a = rf_rdata;
        endcase
    end

    always_comb begin
        case (alu_op)
            3'd0:    alu_res = alu_a + alu_y_q;
            3'd1:    alu_res = alu_a - alu_y_q;
            3'd2:    alu_res = alu_a & alu_y_q;
            3'd3:    alu_res = alu_a | alu_y_q;
            3'd4:    alu_res = alu_a ^ alu_y_q;
            3'd5:    alu_res = {alu_a[WORD_SIZE-2:0], 1'b0};
            3'd6:    alu_res = {1'b0, alu_a[WORD_SIZE-1:1]};
            default: alu_res = alu_y_q;
        endcase
    end

    assign bus = (bus_src == 2'b01) ? alu_res : alu_a;

    // mem_rd/mem_addr are held stable in REQ until mem_ready; the read word is
    // accepted on the rising edge where mem_rd and mem_ready are both high.
    always_comb begin
        state_d    = state_q;
        fetch_done = 1'b0;
        case (state_q)
            S_IDLE: if (fetch_req) state_d = S_REQ;
            S_REQ: begin
                if (mem_ready) begin
                    state_d    = S_DONE;
                    fetch_done = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_req = (state_q == S_REQ);

    always_comb begin
        pc_d = pc_q;
        if (load_pc && !in_req)      pc_d = bus;
        else if (fetch_done)         pc_d = pc_q + WORD_SIZE'(1);
        else if (inc_pc && !in_req)  pc_d = pc_q + WORD_SIZE'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            alu_y_q <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            pc_q    <= PC_RESET;
            state_q <= S_IDLE;
        end else begin
            if (reg_wr_en)  regs_q[reg_wr_sel] <= bus;
            if (load_alu_y) alu_y_q <= bus;
            if (load_mar)   mar_q   <= bus;
            if (load_mdr)   mdr_q   <= bus;
            if (load_flags) z_q     <= (alu_res == '0);
            if (fetch_done) ir_q    <= mem_rdata;
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

`ifdef M2_PU_EXT_FLAGS_EN
    logic c_q, n_q, v_q, c_d, v_d;
    logic a_msb, b_msb, r_msb;

    assign a_msb = alu_a[WORD_SIZE-1];
    assign b_msb = alu_y_q[WORD_SIZE-1];
    assign r_msb = alu_res[WORD_SIZE-1];

    // Carry/borrow out of the MSB recovered from operand and result sign bits.
    always_comb begin
        c_d = 1'b0;
        v_d = 1'b0;
        case (alu_op)
            3'd0: begin
                c_d = (a_msb & b_msb) | ((a_msb | b_msb) & ~r_msb);
                v_d = (a_msb == b_msb) && (r_msb != a_msb);
            end
            3'd1: begin
                c_d = (~a_msb & b_msb) | ((~a_msb | b_msb) & r_msb);
                v_d = (a_msb != b_msb) && (r_msb != a_msb);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (load_flags) begin
            c_q <= c_d;
            n_q <= r_msb;
            v_q <= v_d;
        end
    end

    assign c_flag = c_q;
    assign n_flag = n_q;
    assign v_flag = v_q;
`endif

    assign bus_out     = bus;
    assign mem_rd      = in_req;
    assign mem_addr    = in_req ? pc_q : mar_q;
    assign fetch_busy  = (state_q != S_IDLE);
    assign fetch_state = state_q;
    assign instruction = ir_q;
    assign pc          = pc_q;
    assign mdr         = mdr_q;
    assign z_flag      = z_q;

endmodule

// File: doc/m2_processing_unit.md
M2_PROCESSING_UNIT -- requirements
Module: m2_processing_unit

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, meaning datapath width in bits (legal range 8..32).
REQ-002 The block SHALL have parameter NUM_REGS, default 8, meaning general-register count (power of two, 2..16); RSEL_W = log2(NUM_REGS).
REQ-003 The block SHALL have parameter PC_RESET, default 0, meaning the PC value after reset.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
  clk  in  1  clock, all state updates on its rising edge
  rst  in  1  synchronous active-high reset
  reg_wr_en  in  1  write bus value into register reg_wr_sel
  reg_wr_sel  in  RSEL_W  destination register
  reg_rd_sel  in  RSEL_W  source register for the bus
  bus_src  in  2  bus source: 00 register file, 01 ALU result, 10 MDR, 11 PC
  alu_op  in  3  ALU operation
  load_alu_y  in  1  latch bus into ALU Y operand register
  load_flags  in  1  latch ALU flags
  load_mar  in  1  latch bus into memory address register
  load_mdr  in  1  latch bus into memory data register
  load_pc  in  1  latch bus into PC
  inc_pc  in  1  PC <= PC+1
  fetch_req  in  1  start an instruction fetch
  mem_rdata  in  WORD_SIZE  memory read data
  mem_ready  in  1  memory read data valid
  mem_addr  out  WORD_SIZE  memory address
  mem_rd  out  1  memory read strobe
  fetch_busy  out  1  fetch in progress
  instruction  out  WORD_SIZE  instruction register
  pc  out  WORD_SIZE  program counter
  mdr  out  WORD_SIZE  memory data register
  z_flag  out  1  registered zero flag
  bus_out  out  WORD_SIZE  current internal bus value

Function
REQ-005 bus_out SHALL be combinational from bus_src; the register-file read SHALL be combinational, so a same-cycle write to the read register returns the old value.
REQ-006 The ALU SHALL compute from A = bus and B = ALU Y register: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLL A by 1, 110 SRL A by 1, 111 PASS B; the result SHALL be truncated to WORD_SIZE, with carry discarded.
REQ-007 When load_flags=1, z_flag SHALL take (ALU result == 0) at the next edge and otherwise hold.
REQ-008 PC updates SHALL follow this priority: load_pc, then the fetch-complete increment, then inc_pc. The increment SHALL wrap from 2^WORD_SIZE-1 to 0.
REQ-009 The fetch FSM SHALL have states IDLE, REQ and DONE.
  IDLE: on fetch_req=1, go to REQ.
  REQ: mem_rd=1 and mem_addr=PC; hold until mem_ready=1. Then, on that edge, IR <= mem_rdata, PC <= PC+1, and go to DONE.
  DONE: one cycle, then IDLE.
REQ-010 fetch_busy SHALL be 1 in REQ and DONE. fetch_req SHALL be ignored while fetch_busy=1.
REQ-011 While the FSM is in REQ, load_pc and inc_pc SHALL be ignored. All other loads SHALL remain functional.
REQ-012 Outside REQ, mem_addr SHALL equal MAR and mem_rd SHALL be 0.
REQ-013 mem_ready SHALL be ignored in IDLE and DONE.
REQ-014 When fetch_req and mem_ready are both 1 in IDLE, the block SHALL only enter REQ; the IR SHALL not load that cycle.

Reset
REQ-015 rst SHALL clear all general registers, ALU Y, MAR, MDR, IR, z_flag and all flags to 0, set PC to PC_RESET and the FSM to IDLE, giving mem_rd=0 and fetch_busy=0 in the cycle after reset.
REQ-016 rst asserted while the FSM is in REQ SHALL abort the fetch with no IR load and no PC increment, and rst SHALL override every load input.

Configuration
REQ-017 With macro M2_PU_EXT_FLAGS_EN defined, the block SHALL add outputs c_flag, n_flag and v_flag, loaded with load_flags:
  c_flag: carry out of ADD / borrow of SUB, and 0 for the other ops.
  n_flag: result MSB.
  v_flag: signed overflow for ADD/SUB, and 0 for the other ops.
  Without the macro, these ports and their registers SHALL not exist.

Verification
REQ-018 W=16: write 0x1234 to R3, set bus_src=00 and reg_rd_sel=3 -> bus_out=0x1234. Load Y=0x1234, then SUB with load_flags -> z_flag=1.
REQ-019 Start a fetch with PC=0x0010 and mem_ready delayed 3 cycles with data 0xABCD -> mem_rd=1 for 4 cycles, mem_addr=0x0010, IR=0xABCD, PC=0x0011, fetch_busy low 2 cycles after ready.
REQ-020 PC=0xFFFF with inc_pc -> PC=0x0000. In the same cycle, load_pc=1 and inc_pc=1 with bus=0x0200 -> PC=0x0200.
REQ-021 rst asserted during REQ -> IR stays 0x0000, PC=PC_RESET, FSM IDLE; a later mem_ready pulse has no effect.
REQ-022 With M2_PU_EXT_FLAGS_EN defined: ADD 0x7FFF+0x0001 -> v=1, n=1, c=0, z=0; ADD 0xFFFF+0x0001 -> c=1, z=1, v=0.
